// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-agent handshake bundle for the async FIFO read controller.
// The agent drives rinc; the controller returns address and status.
interface async_fifo_rd_ctrl_if #(
    parameter int ASIZE = 4
);
    logic             rinc;
    logic [ASIZE-1:0] raddr;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   rcount;
    logic             rundflow;

    modport master (
        output rinc,
        input  raddr, rempty, ralmost_empty, rcount, rundflow
    );

    modport slave (
        input  rinc,
        output raddr, rempty, ralmost_empty, rcount, rundflow
    );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer/status controller of the async FIFO: owns the read pointer,
// synchronises the write Gray pointer into rclk and derives empty/occupancy flags.
module async_fifo_rd_ctrl #(
    parameter int ASIZE     = 4,
    parameter int AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [ASIZE:0]       wptr_gray,
    output logic [ASIZE:0]       rptr,
    async_fifo_rd_ctrl_if.slave  rif
);
    localparam logic [ASIZE:0] AE_LIMIT = AE_THRESH[ASIZE:0];

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rq1_wptr;
    logic [ASIZE:0] rq2_wptr;
    logic [ASIZE:0] rbinnext;
    logic [ASIZE:0] rgraynext;
    logic [ASIZE:0] wbin_sync;
    logic [ASIZE:0] occ_next;
    logic           rd_en;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            wbin_sync[i] = ^(rq2_wptr >> i);
        end
    end

    always_comb begin
        rd_en     = rif.rinc & ~rif.rempty;
        rbinnext  = rbin + {{ASIZE{1'b0}}, rd_en};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        occ_next  = wbin_sync - rbinnext;
    end

    assign rif.raddr = rbin[ASIZE-1:0];

    // Flags use next-state pointers so they move on the same edge as the read
    // and compare against the old rq2, which can only err towards empty.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin              <= '0;
            rptr              <= '0;
            rq1_wptr          <= '0;
            rq2_wptr          <= '0;
            rif.rempty        <= 1'b1;
            rif.ralmost_empty <= 1'b1;
            rif.rcount        <= '0;
            rif.rundflow      <= 1'b0;
        end else begin
            rq1_wptr          <= wptr_gray;
            rq2_wptr          <= rq1_wptr;
            rbin              <= rbinnext;
            rptr              <= rgraynext;
            rif.rempty        <= (rgraynext == rq2_wptr);
            rif.rcount        <= occ_next;
            rif.ralmost_empty <= (occ_next <= AE_LIMIT);
            rif.rundflow      <= rif.rinc & rif.rempty;
        end
    end
endmodule
